multicycle_control: RTL and testbench

Moore-style main control FSM with ready-qualified memory handshake, which sequences the shared 32-bit ALU, memory port, register file and PC of the multicycle MIPS datapath. It decodes R-format, lw, sw, beq and j, and drives every datapath select and enable. It also translates ALUOp plus funct into the ALU's {binv, op} encoding (00 AND, 01 OR, 10 add/sub) and counts retired instructions.

---
 rtl/mips_ctrl_pkg.sv | 39 +++
 rtl/alu_control.sv | 33 +++
 rtl/multicycle_control.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: states, opcodes, functs
// and the two levels of ALU control codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC     = 4'd6,
    R_DONE   = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9
  } state_t;

  localparam logic [5:0] OPC_R   = 6'b000000;
  localparam logic [5:0] OPC_LW  = 6'b100011;
  localparam logic [5:0] OPC_SW  = 6'b101011;
  localparam logic [5:0] OPC_BEQ = 6'b000100;
  localparam logic [5:0] OPC_J   = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;

endpackage

// File: rtl/alu_control.sv
// Translates the main FSM's ALUOp and the instruction funct field into the
// ALU's {binv, op} encoding, flagging funct codes the ALU cannot execute.
module alu_control
  import mips_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic       alu_binv,
  output logic [1:0] alu_op,
  output logic       bad_funct
);

  always_comb begin
    alu_binv  = 1'b0;
    alu_op    = ALU_ADD;
    bad_funct = 1'b0;
    case (aluop)
      ALUOP_ADD: alu_op = ALU_ADD;
      ALUOP_SUB: alu_binv = 1'b1;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD: alu_op = ALU_ADD;
          FN_SUB: alu_binv = 1'b1;
          FN_AND: alu_op = ALU_AND;
          FN_OR:  alu_op = ALU_OR;
          default: bad_funct = 1'b1;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath with ready-qualified memory
// handshake and a retired-instruction counter.
//   FETCH    | read instruction, PC += 4 on mem_ready
//   DECODE   | dispatch on opcode, precompute branch target
//   MEM_ADDR | base + sign-extended offset
//   MEM_RD   | load access, wait for mem_ready
//   MEM_WB   | write loaded word to rt
//   MEM_WR   | store access, wait for mem_ready
//   EXEC     | R-format ALU operation
//   R_DONE   | write ALU result to rd
//   BRANCH   | compare and conditionally load branch target
//   JUMP     | load jump target
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUSrcB,
  output logic             alu_binv,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  state_t     state_q, state_d;
  aluop_t     aluop;
  logic       alu_use, dec_bad, retire_now;
  logic       binv_raw, bad_funct;
  logic [1:0] op_raw;

  alu_control u_alu_control (
    .aluop     (aluop),
    .funct     (funct),
    .alu_binv  (binv_raw),
    .alu_op    (op_raw),
    .bad_funct (bad_funct)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    aluop       = ALUOP_ADD;
    alu_use     = 1'b0;
    dec_bad     = 1'b0;
    retire_now  = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    case (state_q)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        alu_use = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        alu_use = 1'b1;
        case (opcode)
          OPC_LW, OPC_SW: state_d = MEM_ADDR;
          OPC_R:          state_d = EXEC;
          OPC_BEQ:        state_d = BRANCH;
          OPC_J:          state_d = JUMP;
          default: begin
            state_d = FETCH;
            dec_bad = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        alu_use = 1'b1;
        state_d = (opcode == OPC_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        state_d    = FETCH;
        retire_now = 1'b1;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          state_d    = FETCH;
          retire_now = 1'b1;
        end
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        aluop   = ALUOP_FUNCT;
        alu_use = 1'b1;
        state_d = R_DONE;
      end
      R_DONE: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        state_d    = FETCH;
        retire_now = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        aluop       = ALUOP_SUB;
        alu_use     = 1'b1;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        state_d     = FETCH;
        retire_now  = 1'b1;
      end
      JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        state_d    = FETCH;
        retire_now = 1'b1;
      end
      default: state_d = FETCH;
    endcase
    // Reset must silence the datapath without waiting for a clock edge.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      PCSource    = 2'b00;
      ALUSrcB     = 2'b00;
    end
  end

  assign alu_binv = alu_use & ~reset & binv_raw;
  assign alu_op   = (alu_use && !reset) ? op_raw : 2'b00;
  assign illegal  = ~reset & (dec_bad | ((state_q == EXEC) & bad_funct));
  assign state    = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           retired <= '0;
    else if (retire_now) retired <= retired + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by
// cycle and compares state plus the full control word against hand-built values.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, ALUSrcA, RegWrite, RegDst;
  logic [1:0]  PCSource, ALUSrcB, alu_op;
  logic        alu_binv, illegal;
  logic [31:0] retired;
  logic [3:0]  state;

  int checks = 0;
  int failures = 0;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .alu_binv(alu_binv), .alu_op(alu_op), .illegal(illegal), .retired(retired),
    .state(state)
  );

  always #5 clk = ~clk;

  // Control word layout, MSB first.
  logic [17:0] word;
  assign word = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, alu_binv, alu_op, illegal};

  localparam logic [17:0] B_PCW  = 18'h1 << 17;
  localparam logic [17:0] B_PCWC = 18'h1 << 16;
  localparam logic [17:0] B_IORD = 18'h1 << 15;
  localparam logic [17:0] B_MRD  = 18'h1 << 14;
  localparam logic [17:0] B_MWR  = 18'h1 << 13;
  localparam logic [17:0] B_IRW  = 18'h1 << 12;
  localparam logic [17:0] B_M2R  = 18'h1 << 11;
  localparam logic [17:0] B_SRCA = 18'h1 << 10;
  localparam logic [17:0] B_RW   = 18'h1 << 9;
  localparam logic [17:0] B_RDST = 18'h1 << 8;
  localparam logic [17:0] PCS_AO = 18'h1 << 6;
  localparam logic [17:0] PCS_J  = 18'h2 << 6;
  localparam logic [17:0] SRCB_4 = 18'h1 << 4;
  localparam logic [17:0] SRCB_I = 18'h2 << 4;
  localparam logic [17:0] SRCB_S = 18'h3 << 4;
  localparam logic [17:0] BINV   = 18'h1 << 3;
  localparam logic [17:0] OP_OR  = 18'h1 << 1;
  localparam logic [17:0] OP_ADD = 18'h2 << 1;
  localparam logic [17:0] ILL    = 18'h1;

  localparam logic [17:0] W_FETCH   = B_MRD | B_IRW | B_PCW | SRCB_4 | OP_ADD;
  localparam logic [17:0] W_FETCH_W = B_MRD | SRCB_4 | OP_ADD;
  localparam logic [17:0] W_DECODE  = SRCB_S | OP_ADD;
  localparam logic [17:0] W_MADDR   = B_SRCA | SRCB_I | OP_ADD;
  localparam logic [17:0] W_MRD     = B_MRD | B_IORD;
  localparam logic [17:0] W_MWB     = B_RW | B_M2R;
  localparam logic [17:0] W_MWR     = B_MWR | B_IORD;
  localparam logic [17:0] W_EX_ADD  = B_SRCA | OP_ADD;
  localparam logic [17:0] W_EX_AND  = B_SRCA;
  localparam logic [17:0] W_EX_OR   = B_SRCA | OP_OR;
  localparam logic [17:0] W_EX_BAD  = B_SRCA | OP_ADD | ILL;
  localparam logic [17:0] W_RDONE   = B_RW | B_RDST;
  localparam logic [17:0] W_BRANCH  = B_SRCA | BINV | OP_ADD | B_PCWC | PCS_AO;
  localparam logic [17:0] W_JUMP    = B_PCW | PCS_J;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MADDR = 4'd2, S_MRD = 4'd3,
                         S_MWB = 4'd4, S_MWR = 4'd5, S_EXEC = 4'd6, S_RDONE = 4'd7,
                         S_BRANCH = 4'd8, S_JUMP = 4'd9;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check the current cycle, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [3:0] es, input logic [17:0] ew);
    #1;
    chk({tag, ".state"}, {28'd0, state}, {28'd0, es});
    chk({tag, ".word"}, {14'd0, word}, {14'd0, ew});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    opcode = 6'b000000;
    funct = 6'b100000;
    mem_ready = 1'b1;
    #2;
    chk("rst.state", {28'd0, state}, 32'd0);
    chk("rst.word", {14'd0, word}, 32'd0);
    chk("rst.retired", retired, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // R add
    cyc("radd.f", S_FETCH, W_FETCH);
    cyc("radd.d", S_DECODE, W_DECODE);
    cyc("radd.e", S_EXEC, W_EX_ADD);
    cyc("radd.w", S_RDONE, W_RDONE);
    chk("radd.retired", retired, 32'd1);

    // lw with two wait cycles in MEM_RD
    opcode = 6'b100011;
    cyc("lw.f", S_FETCH, W_FETCH);
    cyc("lw.d", S_DECODE, W_DECODE);
    cyc("lw.a", S_MADDR, W_MADDR);
    mem_ready = 1'b0;
    cyc("lw.r0", S_MRD, W_MRD);
    chk("lw.wait.retired", retired, 32'd1);
    cyc("lw.r1", S_MRD, W_MRD);
    mem_ready = 1'b1;
    cyc("lw.r2", S_MRD, W_MRD);
    mem_ready = 1'b0;
    cyc("lw.wb", S_MWB, W_MWB);
    chk("lw.retired", retired, 32'd2);

    // FETCH stall, then beq / sw / j back-to-back
    opcode = 6'b000100;
    cyc("fst.f", S_FETCH, W_FETCH_W);
    mem_ready = 1'b1;
    cyc("beq.f", S_FETCH, W_FETCH);
    cyc("beq.d", S_DECODE, W_DECODE);
    cyc("beq.b", S_BRANCH, W_BRANCH);
    opcode = 6'b101011;
    cyc("sw.f", S_FETCH, W_FETCH);
    cyc("sw.d", S_DECODE, W_DECODE);
    cyc("sw.a", S_MADDR, W_MADDR);
    cyc("sw.w", S_MWR, W_MWR);
    opcode = 6'b000010;
    cyc("j.f", S_FETCH, W_FETCH);
    cyc("j.d", S_DECODE, W_DECODE);
    cyc("j.j", S_JUMP, W_JUMP);
    chk("bsj.retired", retired, 32'd5);

    // Illegal opcode
    opcode = 6'b111111;
    cyc("ill.f", S_FETCH, W_FETCH);
    cyc("ill.d", S_DECODE, W_DECODE | ILL);
    opcode = 6'b000000;
    funct = 6'b100100;
    chk("ill.retired", retired, 32'd5);

    // R and / or / bad funct
    cyc("and.f", S_FETCH, W_FETCH);
    cyc("and.d", S_DECODE, W_DECODE);
    cyc("and.e", S_EXEC, W_EX_AND);
    cyc("and.w", S_RDONE, W_RDONE);
    funct = 6'b100101;
    cyc("or.f", S_FETCH, W_FETCH);
    cyc("or.d", S_DECODE, W_DECODE);
    cyc("or.e", S_EXEC, W_EX_OR);
    cyc("or.w", S_RDONE, W_RDONE);
    funct = 6'b101010;
    cyc("bad.f", S_FETCH, W_FETCH);
    cyc("bad.d", S_DECODE, W_DECODE);
    cyc("bad.e", S_EXEC, W_EX_BAD);
    cyc("bad.w", S_RDONE, W_RDONE);
    chk("rfn.retired", retired, 32'd8);

    // Reset while a load waits in MEM_RD
    opcode = 6'b100011;
    cyc("rlw.f", S_FETCH, W_FETCH);
    cyc("rlw.d", S_DECODE, W_DECODE);
    cyc("rlw.a", S_MADDR, W_MADDR);
    mem_ready = 1'b0;
    #1;
    chk("rlw.r.state", {28'd0, state}, {28'd0, S_MRD});
    reset = 1'b1;
    #1;
    chk("rlw.rst.state", {28'd0, state}, 32'd0);
    chk("rlw.rst.word", {14'd0, word}, 32'd0);
    chk("rlw.rst.retired", retired, 32'd0);
    mem_ready = 1'b1;
    #1;
    chk("rlw.rst.word_rdy", {14'd0, word}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc("post.f", S_FETCH, W_FETCH);
    cyc("post.d", S_DECODE, W_DECODE);
    chk("post.retired", retired, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
